// File: rtl/softmax_out_pack_pkg.sv
// -----------------------------------------------------------------------------
// softmax_pkg
// Shared constants and types for the softmax output packer.
//   DATA_NUM_DEFAULT   : beats per softmax row (must match the softmax stage)
//   FIFO_DEPTH_DEFAULT : output FIFO entries (power of 2, at least 4)
//   FP32_W / BF16_W    : lane widths before and after conversion
//   LANES              : lanes per beat
//   BF16_QNAN_BIT      : bf16 mantissa bit forced high to quiet a NaN
//   fifo_entry_t       : one FIFO entry, packed word plus end-of-row flag
// -----------------------------------------------------------------------------
package softmax_pkg;

    localparam int DATA_NUM_DEFAULT   = 192;
    localparam int FIFO_DEPTH_DEFAULT = 16;

    localparam int FP32_W        = 32;
    localparam int BF16_W        = 16;
    localparam int LANES         = 4;
    localparam int BF16_QNAN_BIT = 6;

    localparam int IN_W  = FP32_W * LANES;
    localparam int OUT_W = BF16_W * LANES;

    typedef struct packed {
        logic             last;
        logic [OUT_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/softmax_out_pack_if.sv
// -----------------------------------------------------------------------------
// softmax_out_pack_if
// Groups the packer's two streams: the fp32 result stream coming in from the
// softmax stage (no backpressure) and the packed bf16 ready/valid stream going
// out to the consumer.
//   in_tvalid / in_tdata[127:0]          : input beats, four fp32 lanes
//   m_tvalid / m_tready / m_tdata[63:0]  : output words, four bf16 lanes
//   m_tlast                              : last word of a row
// Modports:
//   master : the packer (sinks input beats, sources output words)
//   slave  : the environment around it
// -----------------------------------------------------------------------------
interface softmax_out_pack_if;
    import softmax_pkg::*;

    logic             in_tvalid;
    logic [IN_W-1:0]  in_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic [OUT_W-1:0] m_tdata;
    logic             m_tlast;

    modport master (
        input  in_tvalid,
        input  in_tdata,
        input  m_tready,
        output m_tvalid,
        output m_tdata,
        output m_tlast
    );

    modport slave (
        output in_tvalid,
        output in_tdata,
        output m_tready,
        input  m_tvalid,
        input  m_tdata,
        input  m_tlast
    );

endinterface

// File: rtl/softmax_bf16_cvt.sv
// -----------------------------------------------------------------------------
// softmax_bf16_cvt
// Combinational fp32 -> bf16 conversion of a single lane.
//   fp32_in[31:0]  : IEEE single-precision value
//   bf16_out[15:0] : converted value
// Build option:
//   SOFTMAX_PACK_RNE_EN defined   -> round to nearest, ties to even
//   SOFTMAX_PACK_RNE_EN undefined -> truncate (upper 16 bits)
// NaNs are always passed through as their upper half with the quiet bit set,
// so a rounding carry can never turn a NaN into Inf. Inf, zero and denormals
// go through the ordinary path without flushing.
// -----------------------------------------------------------------------------
module softmax_bf16_cvt
    import softmax_pkg::*;
(
    input  logic [FP32_W-1:0] fp32_in,
    output logic [BF16_W-1:0] bf16_out
);

    logic              is_nan;
    logic [BF16_W-1:0] upper;
    logic [BF16_W-1:0] rounded;

    assign upper  = fp32_in[FP32_W-1 -: BF16_W];
    assign is_nan = (fp32_in[30:23] == 8'hFF) && (fp32_in[22:0] != 23'd0);

`ifdef SOFTMAX_PACK_RNE_EN
    // Adding 0x7FFF plus the kept LSB to the full word carries into the upper
    // half exactly when the discarded half is above 0x8000, or equal to it
    // with an odd kept LSB. Evaluating that condition directly avoids a 32-bit
    // adder; the 16-bit increment wraps the same way the wide sum would.
    logic [BF16_W-1:0] lower;
    logic              round_up;

    assign lower    = fp32_in[BF16_W-1:0];
    assign round_up = (lower > 16'h8000) || ((lower == 16'h8000) && upper[0]);
    assign rounded  = upper + BF16_W'(round_up);
`else
    assign rounded  = upper;
`endif

    // NaN handling overrides the rounding result in every configuration.
    always_comb begin
        bf16_out = rounded;
        if (is_nan) begin
            bf16_out                = upper;
            bf16_out[BF16_QNAN_BIT] = 1'b1;
        end
    end

endmodule

// File: rtl/softmax_out_pack.sv
// -----------------------------------------------------------------------------
// softmax_out_pack
// Output packer downstream of the softmax stage. Converts each 4-lane fp32
// beat to 4-lane bf16, tags the last beat of every DATA_NUM-beat row and
// buffers the packed words in a first-word-fall-through FIFO so the consumer
// may apply backpressure. Input to output latency is two cycles.
// Parameters:
//   DATA_NUM   : beats per row
//   FIFO_DEPTH : FIFO entries, power of 2 and at least 4
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   stage_start     : level enable, rising edge restarts the stage
//   bus (master)    : in_tvalid/in_tdata input stream,
//                     m_tvalid/m_tready/m_tdata/m_tlast output stream
//   overflow        : sticky, a word was dropped because the FIFO was full
//   rows_done[15:0] : rows fully delivered, wraps modulo 2^16
// Build option: SOFTMAX_PACK_RNE_EN selects round-to-nearest-even in the lane
// converters; otherwise they truncate.
// -----------------------------------------------------------------------------
module softmax_out_pack
    import softmax_pkg::*;
#(
    parameter int DATA_NUM   = DATA_NUM_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stage_start,
    softmax_out_pack_if.master bus,
    output logic               overflow,
    output logic [15:0]        rows_done
);

    localparam int               CNT_W      = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(DATA_NUM - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic             stage_start_q;
    logic             start_pulse;

    logic [OUT_W-1:0] cvt_data;
    logic             c_valid;
    logic [OUT_W-1:0] c_data;
    logic             c_last;
    logic [CNT_W-1:0] beat_cnt;

    fifo_entry_t      mem [FIFO_DEPTH];
    fifo_entry_t      head;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             drop;

    // Edge detector for the stage enable; a restart is the rising edge only.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_start_q <= 1'b0;
        end else begin
            stage_start_q <= stage_start;
        end
    end

    assign start_pulse = stage_start & ~stage_start_q;

    for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
        softmax_bf16_cvt u_cvt (
            .fp32_in  (bus.in_tdata[lane*FP32_W +: FP32_W]),
            .bf16_out (cvt_data[lane*BF16_W +: BF16_W])
        );
    end

    // Conversion register and row position. The beat counter follows every
    // accepted input beat, even those later dropped at the FIFO, so the row
    // boundary stays aligned with the softmax stage. A beat arriving with a
    // start pulse is discarded along with the rest of the state.
    always_ff @(posedge clk) begin
        if (rst || start_pulse) begin
            c_valid  <= 1'b0;
            c_data   <= '0;
            c_last   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            c_valid <= bus.in_tvalid;
            if (bus.in_tvalid) begin
                c_data   <= cvt_data;
                c_last   <= (beat_cnt == LAST_BEAT);
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
            end
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr - rd_ptr) == FULL_COUNT);
    assign head       = mem[rd_ptr[PTR_W-1:0]];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop  = bus.m_tvalid & bus.m_tready;
    assign push = c_valid & (~fifo_full | pop);
    assign drop = c_valid & fifo_full & ~pop;

    // Storage has no reset; stale entries are unreachable once the pointers
    // are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= '{last: c_last, data: c_data};
        end
    end

    // FIFO pointers and status. The clear on a start pulse takes priority over
    // a coinciding pop, so rows_done reads zero after a restart.
    always_ff @(posedge clk) begin
        if (rst || start_pulse) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            rows_done <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop && head.last) begin
                rows_done <= rows_done + 16'd1;
            end
        end
    end

    // The head entry falls through; data and last read as zero when idle and
    // are stable while a word waits because rd_ptr only moves on a pop.
    assign bus.m_tvalid = ~fifo_empty;
    assign bus.m_tdata  = bus.m_tvalid ? head.data : '0;
    assign bus.m_tlast  = bus.m_tvalid & head.last;

endmodule

// File: doc/softmax_out_pack.md
# softmax_out_pack

Output packer directly downstream of the softmax stage. Consumes the four-lane fp32 result stream (`result_tvalid`/`result_tdata`, 128 bits, no backpressure), converts each lane to bf16, and packs the four lanes into one 64-bit word. It tags the last beat of every `DATA_NUM`-beat row and buffers words in a small FIFO so a ready/valid consumer can apply backpressure.

## Interface

Parameters:
- `DATA_NUM`, 192: beats per softmax row; must match the softmax stage.
- `FIFO_DEPTH`, 16: output FIFO entries; must be a power of 2, at least 4.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `stage_start`, in, 1: level stage enable; its rising edge starts a new stage.
- `in_tvalid`, in, 1: input beat valid; driven from softmax `result_tvalid`.
- `in_tdata`, in, 128: four fp32 lanes; lane i is bits [32i+31:32i].
- `m_tvalid`, out, 1: output word valid.
- `m_tready`, in, 1: consumer ready.
- `m_tdata`, out, 64: four bf16 lanes; lane i is bits [16i+15:16i].
- `m_tlast`, out, 1: marks the last word of a row.
- `overflow`, out, 1: sticky flag; a beat was dropped because the FIFO was full.
- `rows_done`, out, 16: count of rows fully delivered; wraps modulo 2^16.

## Operation

- **Stage start:** `start_pulse = stage_start & ~stage_start_q`. On a start pulse, the block synchronously clears the following; an input beat arriving on that cycle is discarded.
  - beat counter
  - FIFO pointers
  - conversion register
  - `overflow`
  - `rows_done`
- **Conversion stage** (register C, capture gated on `in_tvalid`):
  - Each lane is converted independently.
  - NaN (exp=0xFF, mantissa≠0): output the upper 16 bits with bf16 bit 6 forced to 1 (quiet). Applies in all configurations.
  - Inf, zero and denormals: handled by the same rounding rule as normal numbers, with no flushing.
  - Rounding rule: see Configuration.
- **Row tagging:**
  - `beat_cnt` counts from 0 to DATA_NUM-1 and advances on every accepted input beat.
  - The `last` flag stored with the word is `beat_cnt==DATA_NUM-1`. `beat_cnt` then wraps to 0.
  - Dropped beats still advance `beat_cnt`, so row alignment is preserved.
- **FIFO:**
  - Each entry holds 65 bits: the 64-bit word plus `last`.
  - First-word-fall-through.
  - Push when C is valid and the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Pop on `m_tvalid & m_tready`.
- **Overflow:**
  - If C is valid, the FIFO is full and there is no pop in that cycle, the word is dropped and `overflow` is set to 1.
  - `overflow` is cleared only by `rst` or a start pulse.
- **Row completion:** `rows_done` increments on a pop whose `last` flag is 1.
- **Output gating:** `m_tdata` and `m_tlast` are forced to 0 whenever `m_tvalid` is 0.

## Timing

- **Reset values:** `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `overflow`=0, `rows_done`=0; internally, `beat_cnt`=0 and the FIFO is empty.
- **Latency:** 2 cycles from input to output. A beat sampled on edge N is in C after N. It is written to the FIFO on edge N+1, so `m_tvalid` is high after N+1 when the FIFO was empty.
- **Throughput:** one beat per cycle sustained while `m_tready`=1. There is no bubble on simultaneous push and pop, including when the FIFO is full.
- **Handshake:** once `m_tvalid` is asserted, `m_tdata` and `m_tlast` stay stable until the word is accepted.
- **Reset mid-row:** the partial row and all FIFO contents are lost. The next input beat is beat 0.
- **Start pulse coinciding with a pop:** the clear wins, and `rows_done` reads 0 afterwards.

## Configuration

- **`SOFTMAX_PACK_RNE_EN` defined:** round-to-nearest-even. The output is the upper half of x + 0x7FFF + x[16], taken over the 32-bit value. Finite values can round up to ±Inf.
- **`SOFTMAX_PACK_RNE_EN` undefined:** truncation; the output is x[31:16].
- NaN quieting is identical in both configurations.

## Structure

- **Package `softmax_pkg`:**
  - `DATA_NUM` default
  - `FP32_W`=32, `BF16_W`=16, `LANES`=4
  - `BF16_QNAN_BIT`=6
  - typedef for the packed 65-bit FIFO entry
- **Sub-module `softmax_bf16_cvt`:** combinational, one lane, honours the macro; instantiated 4×. The FIFO is written inline.

## Test plan

1. **Basic conversion:** all lanes = 0x3F800000 with `m_tready`=1. Expect `m_tdata`=0x3F803F803F803F80 two cycles later, with `m_tlast`=0.
2. **Rounding:** lanes {0x3F808000, 0x3F818000, 0x7F7FFFFF, 0x7F800001}.
   - With `SOFTMAX_PACK_RNE_EN`: {0x3F80, 0x3F82, 0x7F80, 0x7FC0}.
   - Without: {0x3F80, 0x3F81, 0x7F7F, 0x7FC0}.
3. **Row tagging:** 384 continuous beats with `m_tready`=1. Expect `m_tlast` only on words 192 and 384, `rows_done`=2, and `overflow`=0.
4. **Backpressure:** hold `m_tready`=0 and send 17 beats. Expect 16 words held, `overflow`=1, and the first 16 words drained intact when `m_tready` rises. Then send 175 more beats: `m_tlast` appears on the 175th of these (the dropped beat counted).
5. **Full-FIFO simultaneous push/pop:** fill the FIFO, then set `m_tready`=1 with continuous input. Expect no drop and `overflow` staying 0.
6. **Mid-row restart:** send 100 beats, drop `stage_start`, then re-raise it. Expect the FIFO to be empty and `rows_done`=0. The next 192 beats produce `m_tlast` on beat 192.
